syn_fork: RTL

- Broadcast stage: one packed synapse vector stream in, two identical copies out.
- Each branch has its own DEPTH-entry FIFO, so the two consumers drain independently and may slip up to DEPTH vectors apart.
- Sits upstream of the two-input reduce/accumulate stage. It feeds the two parallel synapse paths whose results are later merged back into one stream.
- Valid/ready handshake on all three ports, same semantics as the rest of the synapse datapath.

---
 rtl/syn_fork.sv | 87 ++++++++
 1 files changed

// File: rtl/syn_fork.sv
// rtl/syn_fork.sv - broadcast one synapse vector stream into two independently drained FIFO branches
// Optional occupancy/skew monitor ports enabled by SYN_FORK_OCC_EN.
module syn_fork #(
  parameter int P     = 64,
  parameter int MWID  = 12,
  parameter int DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [P*MWID-1:0]     syn,
  input  logic                  syn_valid,
  output logic                  syn_ready,
  output logic [P*MWID-1:0]     syn1,
  output logic                  syn1_valid,
  input  logic                  syn1_ready,
  output logic [P*MWID-1:0]     syn2,
  output logic                  syn2_valid,
  input  logic                  syn2_ready
`ifdef SYN_FORK_OCC_EN
  ,
  output logic [$clog2(DEPTH):0] occ1,
  output logic [$clog2(DEPTH):0] occ2,
  output logic [$clog2(DEPTH):0] skew_max
`endif
);

  localparam int W  = P * MWID;
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  // Index 0 is branch 1, index 1 is branch 2.
  logic [W-1:0]  mem    [2][DEPTH];
  logic [AW-1:0] wr_ptr [2];
  logic [AW-1:0] rd_ptr [2];
  logic [CW-1:0] cnt    [2];
  logic [1:0]    rdy;
  logic [1:0]    vld;
  logic [1:0]    pop;
  logic          push;

  assign rdy       = {syn2_ready, syn1_ready};
  assign vld       = {(cnt[1] != '0), (cnt[0] != '0)};
  assign pop       = vld & rdy;
  // Ready looks only at registered counts, so a same-cycle pop of a full FIFO still stalls.
  assign syn_ready = (cnt[0] < FULL) && (cnt[1] < FULL);
  assign push      = syn_valid && syn_ready;

  assign syn1_valid = vld[0];
  assign syn2_valid = vld[1];
  assign syn1       = mem[0][rd_ptr[0]];
  assign syn2       = mem[1][rd_ptr[1]];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        wr_ptr[k] <= '0;
        rd_ptr[k] <= '0;
        cnt[k]    <= '0;
        for (int e = 0; e < DEPTH; e++) mem[k][e] <= '0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (push) begin
          mem[k][wr_ptr[k]] <= syn;
          wr_ptr[k]         <= wr_ptr[k] + 1'b1;
        end
        if (pop[k]) rd_ptr[k] <= rd_ptr[k] + 1'b1;
        if (push && !pop[k])      cnt[k] <= cnt[k] + 1'b1;
        else if (!push && pop[k]) cnt[k] <= cnt[k] - 1'b1;
      end
    end
  end

`ifdef SYN_FORK_OCC_EN
  logic [CW-1:0] skew;
  assign occ1 = cnt[0];
  assign occ2 = cnt[1];
  assign skew = (cnt[0] >= cnt[1]) ? (cnt[0] - cnt[1]) : (cnt[1] - cnt[0]);

  always_ff @(posedge clk) begin
    if (!rst_n)               skew_max <= '0;
    else if (skew > skew_max) skew_max <= skew;
  end
`endif

endmodule
